// File: rtl/mod_ctrl_pkg.sv
// Shared types and constants for the modulation buffer sequencer.
package mod_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH   = 16;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DIV_WIDTH        = 16;
    localparam int CYCLE_WIDTH      = 16;
    localparam int MAX_READ_LATENCY = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [CYCLE_WIDTH-1:0] cycle;
        logic [DIV_WIDTH-1:0]   div;
    } cfg_t;

    localparam cfg_t RST_CFG = '{cycle: '0, div: 16'd1};

    // A divider of zero would stall the sequencer, so it runs at full rate instead.
    function automatic logic [DIV_WIDTH-1:0] norm_div(input logic [DIV_WIDTH-1:0] d);
        return (d == '0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/mod_read_pipe.sv
// Read-token shift register: a token issued with an address emerges as a
// capture strobe exactly READ_LATENCY clocks later. Flush drops all in-flight tokens.
module mod_read_pipe
    import mod_ctrl_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue,
    input  logic flush,
    output logic capture
);

    localparam int DEPTH = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                           (READ_LATENCY < 1) ? 1 : READ_LATENCY;

    logic [DEPTH-1:0] tok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok <= '0;
        end else if (flush) begin
            tok <= DEPTH'(issue);
        end else begin
            tok <= (tok << 1) | DEPTH'(issue);
        end
    end

    // A token maturing on the same edge as a flush is stale and must not strobe.
    assign capture = tok[DEPTH-1] & ~flush;

endmodule

// File: rtl/modulation_controller.sv
// Modulation buffer sequencer: steps ADDR at a divided rate, wraps at a
// programmable cycle, realigns on SYNC. Optional MOD_CTRL_LOOP_COUNT_EN adds LOOP_CNT.
module modulation_controller
    import mod_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int READ_LATENCY = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN,
    input  logic                  SYNC,
    input  logic                  UPDATE,
    input  logic [ADDR_WIDTH-1:0] CYCLE_IN,
    input  logic [DIV_WIDTH-1:0]  FREQ_DIV_IN,
    output logic [ADDR_WIDTH-1:0] ADDR,
    input  logic [DATA_WIDTH-1:0] MOD_IN,
    output logic [DATA_WIDTH-1:0] MOD,
    output logic                  MOD_VALID,
    output logic                  CYCLE_DONE
`ifdef MOD_CTRL_LOOP_COUNT_EN
    ,
    output logic [15:0]           LOOP_CNT
`endif
);

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr, addr_nx;
    logic [DIV_WIDTH-1:0]  div_cnt, div_cnt_nx;
    cfg_t                  active, active_nx, shadow, shadow_nx, upd_cfg;
    logic                  pending, pending_nx;
    logic                  cycle_done, done_nx;
    logic                  issue, flush, mod_clr, realign, capture;
    logic [DATA_WIDTH-1:0] mod_p0;
    logic                  vld_p0;

    assign upd_cfg = '{cycle: CYCLE_WIDTH'(CYCLE_IN), div: norm_div(FREQ_DIV_IN)};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        addr_nx    = addr;
        div_cnt_nx = div_cnt;
        active_nx  = active;
        shadow_nx  = shadow;
        pending_nx = pending;
        done_nx    = 1'b0;
        issue      = 1'b0;
        flush      = 1'b0;
        mod_clr    = 1'b0;
        realign    = 1'b0;
        case (state)
            IDLE: begin
                addr_nx    = '0;
                div_cnt_nx = '0;
                if (pending) begin
                    active_nx  = shadow;
                    pending_nx = 1'b0;
                end
                if (EN) begin
                    state_nx = RUN;
                    issue    = 1'b1;
                end
            end
            RUN: begin
                if (!EN) begin
                    state_nx   = IDLE;
                    addr_nx    = '0;
                    div_cnt_nx = '0;
                    flush      = 1'b1;
                    mod_clr    = 1'b1;
                end else if (SYNC) begin
                    addr_nx    = '0;
                    div_cnt_nx = '0;
                    flush      = 1'b1;
                    issue      = 1'b1;
                    realign    = 1'b1;
                end else if (div_cnt == active.div - 16'd1) begin
                    div_cnt_nx = '0;
                    issue      = 1'b1;
                    if (addr == ADDR_WIDTH'(active.cycle)) begin
                        addr_nx = '0;
                        done_nx = 1'b1;
                        realign = 1'b1;
                    end else begin
                        addr_nx = addr + ADDR_WIDTH'(1);
                    end
                end else begin
                    div_cnt_nx = div_cnt + 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // At a realignment point a coincident UPDATE bypasses the shadow.
        if (realign) begin
            if (UPDATE) begin
                active_nx  = upd_cfg;
                pending_nx = 1'b0;
            end else if (pending) begin
                active_nx  = shadow;
                pending_nx = 1'b0;
            end
        end else if (UPDATE) begin
            shadow_nx  = upd_cfg;
            pending_nx = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr       <= '0;
            div_cnt    <= '0;
            active     <= RST_CFG;
            shadow     <= RST_CFG;
            pending    <= 1'b0;
            cycle_done <= 1'b0;
            mod_p0     <= '0;
            vld_p0     <= 1'b0;
        end else begin
            addr       <= addr_nx;
            div_cnt    <= div_cnt_nx;
            active     <= active_nx;
            shadow     <= shadow_nx;
            pending    <= pending_nx;
            cycle_done <= done_nx;
            vld_p0     <= capture;
            if (mod_clr)      mod_p0 <= '0;
            else if (capture) mod_p0 <= MOD_IN;
        end
    end

    mod_read_pipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_read_pipe (
        .clk    (CLK),
        .rst_n  (RST_N),
        .issue  (issue),
        .flush  (flush),
        .capture(capture)
    );

    assign ADDR       = addr;
    assign MOD        = mod_p0;
    assign MOD_VALID  = vld_p0;
    assign CYCLE_DONE = cycle_done;

`ifdef MOD_CTRL_LOOP_COUNT_EN
    logic [15:0] loop_cnt;
    logic        loop_clr;

    assign loop_clr = (state == RUN) && (!EN || SYNC);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)       loop_cnt <= '0;
        else if (loop_clr) loop_cnt <= '0;
        else if (done_nx)  loop_cnt <= loop_cnt + 16'd1;
    end

    assign LOOP_CNT = loop_cnt;
`else
    // Loop counter not built: LOOP_CNT port is absent.
`endif

endmodule

// File: tb/tb_modulation_controller.sv
// Directed + randomized bench for modulation_controller with a queue-based
// reference model and a latency-2 modulation buffer model.
module tb_modulation_controller;

    localparam int L = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        EN = 1'b0;
    logic        SYNC = 1'b0;
    logic        UPDATE = 1'b0;
    logic [15:0] CYCLE_IN = '0;
    logic [15:0] FREQ_DIV_IN = '0;
    logic [15:0] ADDR;
    logic [7:0]  MOD_IN;
    logic [7:0]  MOD;
    logic        MOD_VALID;
    logic        CYCLE_DONE;
`ifdef MOD_CTRL_LOOP_COUNT_EN
    logic [15:0] LOOP_CNT;
`endif

    int tests = 0;
    int fails = 0;

    modulation_controller #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .READ_LATENCY(L)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .SYNC(SYNC), .UPDATE(UPDATE),
        .CYCLE_IN(CYCLE_IN), .FREQ_DIV_IN(FREQ_DIV_IN), .ADDR(ADDR),
        .MOD_IN(MOD_IN), .MOD(MOD), .MOD_VALID(MOD_VALID), .CYCLE_DONE(CYCLE_DONE)
`ifdef MOD_CTRL_LOOP_COUNT_EN
        , .LOOP_CNT(LOOP_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Buffer contents: low address byte XOR a per-run key; registered once so
    // data sampled two edges after an address change belongs to that address.
    logic [7:0] key = 8'h00;
    logic [7:0] rd_p1;

    function automatic logic [7:0] buf_word(input logic [15:0] a, input logic [7:0] k);
        return a[7:0] ^ k;
    endfunction

    always @(posedge CLK) rd_p1 <= buf_word(ADDR, key);
    assign MOD_IN = rd_p1;

    // Reference model state
    bit m_run, m_pend, m_vld, m_done;
    int m_addr, m_cnt, m_cyc, m_div, s_cyc, s_div, m_mod, m_loop, now;
    int q_due[$];
    int q_addr[$];

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_vld = 0; m_done = 0;
        m_addr = 0; m_cnt = 0; m_cyc = 0; m_div = 1; s_cyc = 0; s_div = 1;
        m_mod = 0; m_loop = 0;
        q_due.delete(); q_addr.delete();
    endtask

    task automatic push_tok(input int a);
        q_due.push_back(now + L);
        q_addr.push_back(a);
    endtask

    task automatic model_edge();
        int  nd;
        bit  realign;
        now++;
        m_vld = 0; m_done = 0; realign = 0;
        nd = (FREQ_DIV_IN == 16'd0) ? 1 : int'(FREQ_DIV_IN);
        if (!m_run) begin
            if (m_pend) begin m_cyc = s_cyc; m_div = s_div; m_pend = 0; end
            m_addr = 0; m_cnt = 0;
            if (EN) begin m_run = 1; push_tok(0); end
        end else if (!EN) begin
            m_run = 0; q_due.delete(); q_addr.delete();
            m_mod = 0; m_addr = 0; m_cnt = 0; m_loop = 0;
        end else if (SYNC) begin
            q_due.delete(); q_addr.delete();
            m_addr = 0; m_cnt = 0; m_loop = 0; realign = 1;
            push_tok(0);
        end else begin
            if (q_due.size() > 0 && q_due[0] == now) begin
                m_mod = int'(buf_word(16'(q_addr[0]), key));
                m_vld = 1;
                void'(q_due.pop_front());
                void'(q_addr.pop_front());
            end
            if (m_cnt == m_div - 1) begin
                m_cnt = 0;
                if (m_addr == m_cyc) begin
                    m_addr = 0; m_done = 1; realign = 1;
                    m_loop = (m_loop + 1) % 65536;
                end else begin
                    m_addr = m_addr + 1;
                end
                push_tok(m_addr);
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (realign) begin
            if (UPDATE) begin m_cyc = int'(CYCLE_IN); m_div = nd; m_pend = 0; end
            else if (m_pend) begin m_cyc = s_cyc; m_div = s_div; m_pend = 0; end
        end else if (UPDATE) begin
            s_cyc = int'(CYCLE_IN); s_div = nd; m_pend = 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("ADDR", {16'h0, ADDR}, 32'(m_addr));
        check("MOD", {24'h0, MOD}, 32'(m_mod));
        check("MOD_VALID", {31'h0, MOD_VALID}, {31'h0, m_vld});
        check("CYCLE_DONE", {31'h0, CYCLE_DONE}, {31'h0, m_done});
`ifdef MOD_CTRL_LOOP_COUNT_EN
        check("LOOP_CNT", {16'h0, LOOP_CNT}, 32'(m_loop));
`endif
    endtask

    task automatic tick(input bit upd, input bit sy);
        UPDATE = upd;
        SYNC   = sy;
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs();
        UPDATE = 1'b0;
        SYNC   = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic set_cfg(input logic [15:0] c, input logic [15:0] d);
        CYCLE_IN    = c;
        FREQ_DIV_IN = d;
    endtask

    task automatic wait_addr(input int target, input int limit);
        bit found = 0;
        for (int i = 0; i < limit && !found; i++) begin
            if (m_addr == target) found = 1;
            else tick(1'b0, 1'b0);
        end
        check("wait_addr", {31'h0, found}, 32'd1);
    endtask

    initial begin
        model_reset();
        now = 0;
        #3;
        check_outputs();
        @(negedge CLK);
        RST_N = 1'b1;

        // cycle=3 div=1, buffer = address byte
        set_cfg(16'd3, 16'd1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);          // SYNC in IDLE is ignored
        EN = 1'b1;
        run(20);

        // div=5 cycle=2, then FREQ_DIV_IN=0 treated as 1
        set_cfg(16'd2, 16'd5);
        tick(1'b1, 1'b0);
        run(40);
        set_cfg(16'd2, 16'd0);
        tick(1'b1, 1'b0);
        run(30);

        // cycle=7 running, UPDATE cycle=1 at ADDR=4
        set_cfg(16'd7, 16'd1);
        tick(1'b1, 1'b1);
        wait_addr(4, 20);
        set_cfg(16'd1, 16'd1);
        tick(1'b1, 1'b0);
        run(10);
        // UPDATE coincident with wrap applies immediately
        wait_addr(1, 10);
        set_cfg(16'd4, 16'd1);
        tick(1'b1, 1'b0);
        run(12);

        // SYNC at ADDR=5 with tokens in flight
        set_cfg(16'd7, 16'd1);
        tick(1'b1, 1'b1);
        wait_addr(5, 20);
        tick(1'b0, 1'b1);
        run(10);

        // cycle=0 with div=3
        set_cfg(16'd0, 16'd3);
        tick(1'b1, 1'b1);
        run(15);

        // EN dropped mid-run, SYNC+EN together from IDLE
        set_cfg(16'd5, 16'd2);
        tick(1'b1, 1'b1);
        run(7);
        EN = 1'b0;
        run(6);
        EN = 1'b1;
        tick(1'b0, 1'b1);
        run(10);

        // Randomized phase with new buffer key (changed while idle)
        EN = 1'b0;
        run(4);
        key = 8'($urandom);
        run(2);
        for (int i = 0; i < 400; i++) begin
            EN = ($urandom_range(0, 15) != 0);
            set_cfg(16'($urandom_range(0, 6)), 16'($urandom_range(0, 4)));
            tick($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end

        // Async reset mid-run loses pending shadow config
        EN = 1'b1;
        set_cfg(16'd6, 16'd1);
        tick(1'b1, 1'b1);
        run(5);
        set_cfg(16'd2, 16'd3);
        tick(1'b1, 1'b0);
        run(1);
        RST_N = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge CLK);
        RST_N = 1'b1;
        run(12);                   // default cycle=0 div=1

`ifdef MOD_CTRL_LOOP_COUNT_EN
        EN = 1'b0;
        run(2);
        set_cfg(16'd1, 16'd1);
        tick(1'b1, 1'b0);
        EN = 1'b1;
        tick(1'b0, 1'b0);
        run(10);
        check("LOOP_CNT_after_10", {16'h0, LOOP_CNT}, 32'd5);
        tick(1'b0, 1'b1);
        check("LOOP_CNT_sync_clear", {16'h0, LOOP_CNT}, 32'd0);
`endif

        // Full-range cycle: 0xFFFF wraps to 0
        EN = 1'b1;
        set_cfg(16'hFFFF, 16'd1);
        tick(1'b1, 1'b1);
        run(65540);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
